// File: rtl/axis_sync_fifo.sv
// ============================================================================
//  Module      : axis_sync_fifo
//  Description : Single-clock AXI-Stream FIFO carrying TDATA/TKEEP/TLAST.
//                Decouples upstream and downstream backpressure and holds up
//                to DEPTH beats. Define AXIS_FIFO_PACKET_MODE_EN to build the
//                store-and-forward variant, which withholds output until a
//                complete packet is buffered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    s_axis_TVALID,
    output logic                    s_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]   s_axis_TDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axis_TKEEP,
    input  logic                    s_axis_TLAST,
    output logic                    m_axis_TVALID,
    input  logic                    m_axis_TREADY,
    output logic [DATA_WIDTH-1:0]   m_axis_TDATA,
    output logic [DATA_WIDTH/8-1:0] m_axis_TKEEP,
    output logic                    m_axis_TLAST,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_occ_w  = c_addr_w + 1;
    localparam int c_keep_w = DATA_WIDTH / 8;
    localparam int c_word_w = DATA_WIDTH + c_keep_w + 1;

    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
    localparam logic [c_occ_w-1:0]  c_occ_one = c_occ_w'(1);
    localparam logic [c_occ_w-1:0]  c_occ_full = c_occ_w'(DEPTH);

    // Each entry is packed as {TLAST, TKEEP, TDATA}
    logic [c_word_w-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0]  r_occ;

    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    logic [c_word_w-1:0] w_head;

    // Ready depends only on registered occupancy, never on m_axis_TREADY,
    // so a pop from full re-opens the input one cycle later.
    assign s_axis_TREADY = ARESETn & (r_occ != c_occ_full);
    assign m_axis_TVALID = ARESETn & w_out_valid;

    assign w_push = s_axis_TVALID & s_axis_TREADY;
    assign w_pop  = m_axis_TVALID & m_axis_TREADY;

    assign w_head        = r_mem[r_rd_ptr];
    assign m_axis_TDATA  = w_head[DATA_WIDTH-1:0];
    assign m_axis_TKEEP  = w_head[DATA_WIDTH +: c_keep_w];
    assign m_axis_TLAST  = w_head[c_word_w-1];
    assign occupancy     = r_occ;

    // Storage write; contents are intentionally not cleared by reset
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_TLAST, s_axis_TKEEP, s_axis_TDATA};
        end
    end

    // Pointer and occupancy bookkeeping; full/empty come from occupancy
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_occ_one;
                2'b01:   r_occ <= r_occ - c_occ_one;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam logic [0:0] c_st_hold    = 1'b0;
    localparam logic [0:0] c_st_release = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_occ_w-1:0] r_pkt_cnt;
    logic               w_pkt_valid;
    logic               w_fsm_pop;

    // Count of complete packets (stored TLAST beats) in the buffer
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_push & s_axis_TLAST, w_pop & m_axis_TLAST})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + c_occ_one;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - c_occ_one;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    // Output-release state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= c_st_hold;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD gates output until a whole packet is present, or the buffer is
    // full with no TLAST (oversize packet goes cut-through). RELEASE streams
    // the rest of the packet as data arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_pkt_valid = 1'b0;
        w_fsm_pop   = 1'b0;
        case (r_state)
            c_st_hold: begin
                w_pkt_valid = (r_pkt_cnt != '0) ||
                              ((r_occ == c_occ_full) && (r_pkt_cnt == '0));
                w_fsm_pop   = w_pkt_valid & m_axis_TREADY;
                if (w_fsm_pop && !m_axis_TLAST) begin
                    w_state_nxt = c_st_release;
                end
            end
            default: begin
                w_pkt_valid = (r_occ != '0);
                w_fsm_pop   = w_pkt_valid & m_axis_TREADY;
                if (w_fsm_pop && m_axis_TLAST) begin
                    w_state_nxt = c_st_hold;
                end
            end
        endcase
    end

    assign w_out_valid = w_pkt_valid;
`else
    assign w_out_valid = (r_occ != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
// ============================================================================
//  Module      : tb_axis_sync_fifo
//  Description : Directed self-checking bench for axis_sync_fifo (DEPTH=4).
//                Packet-mode scenarios are selected by
//                AXIS_FIFO_PACKET_MODE_EN, matching the design build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_sync_fifo;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int DP = 4;
    localparam int OW = 3;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          s_axis_TVALID;
    logic          s_axis_TREADY;
    logic [DW-1:0] s_axis_TDATA;
    logic [KW-1:0] s_axis_TKEEP;
    logic          s_axis_TLAST;
    logic          m_axis_TVALID;
    logic          m_axis_TREADY;
    logic [DW-1:0] m_axis_TDATA;
    logic [KW-1:0] m_axis_TKEEP;
    logic          m_axis_TLAST;
    logic [OW-1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    axis_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) u_dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .s_axis_TVALID (s_axis_TVALID),
        .s_axis_TREADY (s_axis_TREADY),
        .s_axis_TDATA  (s_axis_TDATA),
        .s_axis_TKEEP  (s_axis_TKEEP),
        .s_axis_TLAST  (s_axis_TLAST),
        .m_axis_TVALID (m_axis_TVALID),
        .m_axis_TREADY (m_axis_TREADY),
        .m_axis_TDATA  (m_axis_TDATA),
        .m_axis_TKEEP  (m_axis_TKEEP),
        .m_axis_TLAST  (m_axis_TLAST),
        .occupancy     (occupancy)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn       = 1'b0;
        s_axis_TVALID = 1'b1;
        s_axis_TDATA  = 32'hDEAD_BEEF;
        s_axis_TKEEP  = 4'hF;
        s_axis_TLAST  = 1'b1;
        m_axis_TREADY = 1'b0;
        repeat (3) step();
        n_checks++;
        if (s_axis_TREADY !== 1'b0) begin n_errors++; $display("FAIL reset_tready got=%b want=0", s_axis_TREADY); end
        n_checks++;
        if (m_axis_TVALID !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid got=%b want=0", m_axis_TVALID); end
        n_checks++;
        if (occupancy !== 3'd0) begin n_errors++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        ARESETn       = 1'b1;
        s_axis_TVALID = 1'b0;
        step();
        n_checks++;
        if (s_axis_TREADY !== 1'b1) begin n_errors++; $display("FAIL release_tready got=%b want=1", s_axis_TREADY); end
        n_checks++;
        if (m_axis_TVALID !== 1'b0 || occupancy !== 3'd0) begin
            n_errors++; $display("FAIL release_empty got tvalid=%b occ=%0d want 0/0", m_axis_TVALID, occupancy);
        end
    endtask

    task automatic test_fill();
        m_axis_TREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axis_TVALID = 1'b1;
            s_axis_TDATA  = 32'hA0 + 32'(i);
            s_axis_TKEEP  = 4'hF;
            s_axis_TLAST  = 1'b1;
            n_checks++;
            if (s_axis_TREADY !== 1'b1) begin n_errors++; $display("FAIL fill_tready[%0d] got=%b want=1", i, s_axis_TREADY); end
            step();
            n_checks++;
            if (occupancy !== 3'(i + 1)) begin n_errors++; $display("FAIL fill_occ[%0d] got=%0d want=%0d", i, occupancy, i + 1); end
        end
        n_checks++;
        if (s_axis_TREADY !== 1'b0) begin n_errors++; $display("FAIL full_tready got=%b want=0", s_axis_TREADY); end
        n_checks++;
        if (m_axis_TVALID !== 1'b1 || m_axis_TDATA !== 32'hA0) begin
            n_errors++; $display("FAIL full_head got v=%b d=%h want 1/a0", m_axis_TVALID, m_axis_TDATA);
        end
        s_axis_TDATA = 32'hA4;
        step();
        n_checks++;
        if (occupancy !== 3'd4 || m_axis_TDATA !== 32'hA0) begin
            n_errors++; $display("FAIL full_hold got occ=%0d d=%h want 4/a0", occupancy, m_axis_TDATA);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp_q[$];
        int idx = 0;
        int cyc = 0;
        logic push, pop;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        m_axis_TREADY = 1'b1;
        while ((exp_q.size() != 0 || idx < 4) && cyc < 40) begin
            s_axis_TVALID = (idx < 4);
            s_axis_TDATA  = 32'hB0 + 32'(idx);
            s_axis_TKEEP  = 4'hF;
            s_axis_TLAST  = 1'b1;
            n_checks++;
            if (s_axis_TREADY !== (exp_q.size() != DP)) begin
                n_errors++; $display("FAIL drain_tready cyc=%0d got=%b want=%b", cyc, s_axis_TREADY, exp_q.size() != DP);
            end
            push = s_axis_TVALID && s_axis_TREADY;
            pop  = m_axis_TVALID && m_axis_TREADY;
            if (exp_q.size() != 0) begin
                n_checks++;
                if (!pop || m_axis_TDATA !== exp_q[0]) begin
                    n_errors++; $display("FAIL drain_data cyc=%0d got v=%b d=%h want %h", cyc, m_axis_TVALID, m_axis_TDATA, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (push) begin exp_q.push_back(s_axis_TDATA); idx++; end
            step();
            n_checks++;
            if (occupancy !== 3'(exp_q.size())) begin
                n_errors++; $display("FAIL drain_occ cyc=%0d got=%0d want=%0d", cyc, occupancy, exp_q.size());
            end
            cyc++;
        end
        s_axis_TVALID = 1'b0;
        n_checks++;
        if (cyc >= 40 || m_axis_TVALID !== 1'b0) begin
            n_errors++; $display("FAIL drain_done got cyc=%0d tvalid=%b want <40/0", cyc, m_axis_TVALID);
        end
    endtask

`ifndef AXIS_FIFO_PACKET_MODE_EN
    task automatic test_fall_through();
        m_axis_TREADY = 1'b0;
        s_axis_TVALID = 1'b1;
        s_axis_TDATA  = 32'hC5C5_0001;
        s_axis_TKEEP  = 4'h0;
        s_axis_TLAST  = 1'b1;
        n_checks++;
        if (m_axis_TVALID !== 1'b0) begin n_errors++; $display("FAIL ft_pre got=%b want=0", m_axis_TVALID); end
        step();
        s_axis_TVALID = 1'b0;
        n_checks++;
        if (m_axis_TVALID !== 1'b1 || m_axis_TDATA !== 32'hC5C5_0001 || m_axis_TKEEP !== 4'h0 || m_axis_TLAST !== 1'b1) begin
            n_errors++; $display("FAIL ft_beat got v=%b d=%h k=%h l=%b want 1/c5c50001/0/1",
                                 m_axis_TVALID, m_axis_TDATA, m_axis_TKEEP, m_axis_TLAST);
        end
        m_axis_TREADY = 1'b1;
        step();
        m_axis_TREADY = 1'b0;
        n_checks++;
        if (m_axis_TVALID !== 1'b0 || occupancy !== 3'd0) begin
            n_errors++; $display("FAIL ft_empty got v=%b occ=%0d want 0/0", m_axis_TVALID, occupancy);
        end
    endtask
`else
    task automatic test_packet();
        m_axis_TREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axis_TVALID = 1'b1;
            s_axis_TDATA  = 32'hD0 + 32'(i);
            s_axis_TKEEP  = 4'hF;
            s_axis_TLAST  = (i == 2);
            n_checks++;
            if (m_axis_TVALID !== 1'b0) begin n_errors++; $display("FAIL pkt_hold[%0d] got=%b want=0", i, m_axis_TVALID); end
            step();
        end
        s_axis_TVALID = 1'b0;
        m_axis_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_axis_TVALID !== 1'b1 || m_axis_TDATA !== 32'hD0 + 32'(i) || m_axis_TLAST !== (i == 2)) begin
                n_errors++; $display("FAIL pkt_out[%0d] got v=%b d=%h l=%b want 1/%h/%b",
                                     i, m_axis_TVALID, m_axis_TDATA, m_axis_TLAST, 32'hD0 + 32'(i), i == 2);
            end
            step();
        end
        m_axis_TREADY = 1'b0;
        n_checks++;
        if (m_axis_TVALID !== 1'b0 || occupancy !== 3'd0) begin
            n_errors++; $display("FAIL pkt_empty got v=%b occ=%0d want 0/0", m_axis_TVALID, occupancy);
        end
    endtask

    task automatic test_escape();
        logic [DW-1:0] exp_q[$];
        int idx = 0;
        int cyc = 0;
        logic push;
        m_axis_TREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axis_TVALID = 1'b1;
            s_axis_TDATA  = 32'hE0 + 32'(i);
            s_axis_TKEEP  = 4'hF;
            s_axis_TLAST  = 1'b0;
            exp_q.push_back(s_axis_TDATA);
            step();
            idx++;
            n_checks++;
            if (m_axis_TVALID !== (i == 3)) begin
                n_errors++; $display("FAIL esc_valid[%0d] got=%b want=%b", i, m_axis_TVALID, i == 3);
            end
        end
        m_axis_TREADY = 1'b1;
        while ((exp_q.size() != 0 || idx < 6) && cyc < 40) begin
            s_axis_TVALID = (idx < 6);
            s_axis_TDATA  = 32'hE0 + 32'(idx);
            s_axis_TLAST  = (idx == 5);
            push = s_axis_TVALID && s_axis_TREADY;
            n_checks++;
            if (m_axis_TVALID !== (exp_q.size() != 0) ||
                (exp_q.size() != 0 && m_axis_TDATA !== exp_q[0])) begin
                n_errors++; $display("FAIL esc_stream cyc=%0d got v=%b d=%h want %b/%h",
                                     cyc, m_axis_TVALID, m_axis_TDATA, exp_q.size() != 0,
                                     (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
            if (m_axis_TVALID) void'(exp_q.pop_front());
            if (push) begin exp_q.push_back(s_axis_TDATA); idx++; end
            step();
            cyc++;
        end
        s_axis_TVALID = 1'b0;
        m_axis_TREADY = 1'b0;
        n_checks++;
        if (cyc >= 40 || m_axis_TVALID !== 1'b0) begin
            n_errors++; $display("FAIL esc_done got cyc=%0d v=%b want <40/0", cyc, m_axis_TVALID);
        end
        s_axis_TVALID = 1'b1;
        s_axis_TDATA  = 32'hF0;
        s_axis_TLAST  = 1'b0;
        step();
        n_checks++;
        if (m_axis_TVALID !== 1'b0 || occupancy !== 3'd1) begin
            n_errors++; $display("FAIL esc_back_hold got v=%b occ=%0d want 0/1", m_axis_TVALID, occupancy);
        end
        s_axis_TDATA = 32'hF1;
        s_axis_TLAST = 1'b1;
        step();
        s_axis_TVALID = 1'b0;
        n_checks++;
        if (m_axis_TVALID !== 1'b1 || m_axis_TDATA !== 32'hF0) begin
            n_errors++; $display("FAIL esc_next_pkt got v=%b d=%h want 1/f0", m_axis_TVALID, m_axis_TDATA);
        end
        m_axis_TREADY = 1'b1;
        repeat (2) step();
        m_axis_TREADY = 1'b0;
    endtask
`endif

    task automatic test_backpressure();
        logic [KW+DW:0] exp_q[$];
        logic [KW+DW:0] prev_word = '0;
        logic [KW+DW:0] cur_word;
        logic prev_hold = 1'b0;
        logic push, pop;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while (recv < 64 && cyc < 3000) begin
            m_axis_TREADY = 1'($urandom_range(0, 1));
            s_axis_TVALID = (sent < 64) && ($urandom_range(0, 3) != 0);
            s_axis_TDATA  = $urandom();
            s_axis_TKEEP  = 4'($urandom_range(0, 15));
            s_axis_TLAST  = (sent == 63) ? 1'b1 : ($urandom_range(0, 3) == 0);
            cur_word = {m_axis_TLAST, m_axis_TKEEP, m_axis_TDATA};
            if (prev_hold) begin
                n_checks++;
                if (m_axis_TVALID !== 1'b1 || cur_word !== prev_word) begin
                    n_errors++; $display("FAIL bp_stable cyc=%0d got v=%b w=%h want 1/%h", cyc, m_axis_TVALID, cur_word, prev_word);
                end
            end
            push = s_axis_TVALID && s_axis_TREADY;
            pop  = m_axis_TVALID && m_axis_TREADY;
            if (pop) begin
                n_checks++;
                if (exp_q.size() == 0 || cur_word !== exp_q[0]) begin
                    n_errors++; $display("FAIL bp_data beat=%0d got=%h want=%h", recv, cur_word,
                                         (exp_q.size() != 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (push) begin
                exp_q.push_back({s_axis_TLAST, s_axis_TKEEP, s_axis_TDATA});
                sent++;
            end
            prev_hold = m_axis_TVALID && !pop;
            prev_word = cur_word;
            step();
            cyc++;
        end
        s_axis_TVALID = 1'b0;
        m_axis_TREADY = 1'b0;
        n_checks++;
        if (recv != 64 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL bp_count got recv=%0d left=%0d want 64/0", recv, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        m_axis_TREADY = 1'b0;
        s_axis_TVALID = 1'b1;
        s_axis_TKEEP  = 4'hF;
        s_axis_TLAST  = 1'b1;
        s_axis_TDATA  = 32'h11;
        step();
        s_axis_TDATA  = 32'h22;
        step();
        n_checks++;
        if (occupancy !== 3'd2) begin n_errors++; $display("FAIL mr_pre_occ got=%0d want=2", occupancy); end
        ARESETn = 1'b0;
        step();
        n_checks++;
        if (occupancy !== 3'd0 || m_axis_TVALID !== 1'b0 || s_axis_TREADY !== 1'b0) begin
            n_errors++; $display("FAIL mr_in_reset got occ=%0d v=%b r=%b want 0/0/0", occupancy, m_axis_TVALID, s_axis_TREADY);
        end
        ARESETn       = 1'b1;
        s_axis_TVALID = 1'b0;
        step();
        n_checks++;
        if (occupancy !== 3'd0 || m_axis_TVALID !== 1'b0 || s_axis_TREADY !== 1'b1) begin
            n_errors++; $display("FAIL mr_after got occ=%0d v=%b r=%b want 0/0/1", occupancy, m_axis_TVALID, s_axis_TREADY);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
`ifndef AXIS_FIFO_PACKET_MODE_EN
        test_fall_through();
`else
        test_packet();
        test_escape();
`endif
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
